// File: rtl/chunk_sequencer_if.sv
// chunk_sequencer_if: handshake and fake-line control bundle between the chunk sequencer and bus control.
interface chunk_sequencer_if #(
   parameter int BUF_SIZE = 9,
   parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1)
);
   logic comm_active;
   logic bus_ready;
   logic [BUF_SIZE-1:0] real_mosi_data;
   logic cmd_next_chunk;
   logic cmd_finish;
   logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size;
   logic fake_miso_select;
   logic fake_mosi_select;
   logic [BUF_SIZE-1:0] fake_miso_data;
   logic [BUF_SIZE-1:0] fake_mosi_data;
   modport master (
      input comm_active, bus_ready, real_mosi_data,
      output cmd_next_chunk, cmd_finish, next_chunk_size,
      output fake_miso_select, fake_mosi_select, fake_miso_data, fake_mosi_data
   );
   modport slave (
      output comm_active, bus_ready, real_mosi_data,
      input cmd_next_chunk, cmd_finish, next_chunk_size,
      input fake_miso_select, fake_mosi_select, fake_miso_data, fake_mosi_data
   );
endinterface

// File: rtl/chunk_sequencer.sv
// chunk_sequencer: steps bus control through a host-loaded table of chunk descriptors,
// one chunk per step, with optional MOSI match checks that end the sequence early.
module chunk_sequencer #(
   parameter int BUF_SIZE = 9,
   parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
   parameter int NUM_STEPS = 4,
   parameter int STEP_IDX_WIDTH = $clog2(NUM_STEPS)
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic enable,
   chunk_sequencer_if.master bus,
   input  logic cfg_we,
   input  logic [STEP_IDX_WIDTH-1:0] cfg_addr,
   input  logic [CHUNK_SIZE_WIDTH-1:0] cfg_size,
   input  logic cfg_miso_sel,
   input  logic cfg_mosi_sel,
   input  logic [BUF_SIZE-1:0] cfg_miso_data,
   input  logic [BUF_SIZE-1:0] cfg_mosi_data,
   input  logic cfg_match_en,
   input  logic [BUF_SIZE-1:0] cfg_match_mask,
   input  logic [BUF_SIZE-1:0] cfg_match_value,
   input  logic cfg_last,
   output logic busy,
   output logic [STEP_IDX_WIDTH-1:0] step_idx,
   output logic seq_done,
   output logic seq_abort
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIN_ISSUE, FIN_WAIT} state_t;
   state_t state;
   logic [CHUNK_SIZE_WIDTH-1:0] tbl_size [NUM_STEPS];
   logic [BUF_SIZE-1:0] tbl_miso_data [NUM_STEPS];
   logic [BUF_SIZE-1:0] tbl_mosi_data [NUM_STEPS];
   logic [BUF_SIZE-1:0] tbl_mask [NUM_STEPS];
   logic [BUF_SIZE-1:0] tbl_value [NUM_STEPS];
   logic [NUM_STEPS-1:0] tbl_miso_sel, tbl_mosi_sel, tbl_match_en, tbl_last;
   logic start, mismatch, seq_end;
   logic [STEP_IDX_WIDTH-1:0] nxt;
   logic [CHUNK_SIZE_WIDTH-1:0] nxt_size;
   assign busy = state != IDLE;
   assign start = state == IDLE && bus.comm_active && enable;
   assign nxt = busy ? step_idx + 1'b1 : '0;
   // a zero-size descriptor would stall bus control, so it is issued as one bit
   assign nxt_size = tbl_size[nxt] == '0 ? CHUNK_SIZE_WIDTH'(1) : tbl_size[nxt];
   assign mismatch = tbl_match_en[step_idx] &&
                     ((bus.real_mosi_data & tbl_mask[step_idx]) != tbl_value[step_idx]);
   assign seq_end = mismatch || tbl_last[step_idx] || step_idx == STEP_IDX_WIDTH'(NUM_STEPS - 1);
   always_ff @(posedge sys_clk or negedge rst)
      if (!rst) begin
         for (int i = 0; i < NUM_STEPS; i++) begin
            tbl_size[i] <= '0;
            tbl_miso_data[i] <= '0;
            tbl_mosi_data[i] <= '0;
            tbl_mask[i] <= '0;
            tbl_value[i] <= '0;
         end
         tbl_miso_sel <= '0;
         tbl_mosi_sel <= '0;
         tbl_match_en <= '0;
         tbl_last <= '0;
      end else if (cfg_we && !busy && !start) begin
         tbl_size[cfg_addr] <= cfg_size;
         tbl_miso_data[cfg_addr] <= cfg_miso_data;
         tbl_mosi_data[cfg_addr] <= cfg_mosi_data;
         tbl_mask[cfg_addr] <= cfg_match_mask;
         tbl_value[cfg_addr] <= cfg_match_value;
         tbl_miso_sel[cfg_addr] <= cfg_miso_sel;
         tbl_mosi_sel[cfg_addr] <= cfg_mosi_sel;
         tbl_match_en[cfg_addr] <= cfg_match_en;
         tbl_last[cfg_addr] <= cfg_last;
      end
   always_ff @(posedge sys_clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         step_idx <= '0;
         bus.cmd_next_chunk <= 1'b0;
         bus.cmd_finish <= 1'b0;
         bus.next_chunk_size <= '0;
         bus.fake_miso_select <= 1'b0;
         bus.fake_mosi_select <= 1'b0;
         bus.fake_miso_data <= '0;
         bus.fake_mosi_data <= '0;
         seq_done <= 1'b0;
         seq_abort <= 1'b0;
      end else begin
         seq_done <= 1'b0;
         seq_abort <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  step_idx <= '0;
                  bus.next_chunk_size <= nxt_size;
                  bus.fake_miso_select <= tbl_miso_sel[nxt];
                  bus.fake_mosi_select <= tbl_mosi_sel[nxt];
                  bus.fake_miso_data <= tbl_miso_data[nxt];
                  bus.fake_mosi_data <= tbl_mosi_data[nxt];
                  bus.cmd_next_chunk <= 1'b1;
                  state <= ISSUE;
               end
            ISSUE, WAIT:
               // losing the transaction mid-chunk wins over a same-cycle bus_ready
               if (!bus.comm_active) begin
                  bus.cmd_next_chunk <= 1'b0;
                  bus.next_chunk_size <= '0;
                  bus.fake_miso_select <= 1'b0;
                  bus.fake_mosi_select <= 1'b0;
                  bus.fake_miso_data <= '0;
                  bus.fake_mosi_data <= '0;
                  seq_abort <= 1'b1;
                  state <= IDLE;
               end else if (state == ISSUE) begin
                  bus.cmd_next_chunk <= 1'b0;
                  state <= WAIT;
               end else if (bus.bus_ready) begin
                  if (seq_end) begin
                     bus.next_chunk_size <= '0;
                     bus.cmd_finish <= 1'b1;
                     if (mismatch) begin
                        bus.fake_miso_select <= 1'b0;
                        bus.fake_mosi_select <= 1'b0;
                     end
                     state <= FIN_ISSUE;
                  end else begin
                     step_idx <= nxt;
                     bus.next_chunk_size <= nxt_size;
                     bus.fake_miso_select <= tbl_miso_sel[nxt];
                     bus.fake_mosi_select <= tbl_mosi_sel[nxt];
                     bus.fake_miso_data <= tbl_miso_data[nxt];
                     bus.fake_mosi_data <= tbl_mosi_data[nxt];
                     bus.cmd_next_chunk <= 1'b1;
                     state <= ISSUE;
                  end
               end
            FIN_ISSUE: begin
               bus.cmd_finish <= 1'b0;
               state <= FIN_WAIT;
            end
            FIN_WAIT:
               if (!bus.comm_active) begin
                  bus.next_chunk_size <= '0;
                  bus.fake_miso_select <= 1'b0;
                  bus.fake_mosi_select <= 1'b0;
                  bus.fake_miso_data <= '0;
                  bus.fake_mosi_data <= '0;
                  seq_done <= 1'b1;
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_chunk_sequencer.sv
// tb_chunk_sequencer: directed runs of the chunk sequencer; a scoreboard queue holds the
// hand-computed command/done/abort events and a negedge monitor checks each one as it appears.
module tb_chunk_sequencer;
   logic sys_clk = 1'b0;
   logic rst, enable, cfg_we;
   logic [1:0] cfg_addr;
   logic [3:0] cfg_size;
   logic cfg_miso_sel, cfg_mosi_sel, cfg_match_en, cfg_last;
   logic [8:0] cfg_miso_data, cfg_mosi_data, cfg_match_mask, cfg_match_value;
   logic busy, seq_done, seq_abort;
   logic [1:0] step_idx;
   int checks = 0;
   int errors = 0;
   typedef struct packed {
      logic [1:0] kind;
      logic [3:0] size;
      logic ms;
      logic os;
      logic [8:0] md;
      logic [8:0] od;
      logic [1:0] step;
   } ev_t;
   ev_t exp_q[$];
   ev_t obs, ex;
   logic prev_next = 1'b0;
   logic prev_fin = 1'b0;

   chunk_sequencer_if #(.BUF_SIZE(9)) b();

   chunk_sequencer dut (
      .sys_clk(sys_clk), .rst(rst), .enable(enable), .bus(b),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_size(cfg_size),
      .cfg_miso_sel(cfg_miso_sel), .cfg_mosi_sel(cfg_mosi_sel),
      .cfg_miso_data(cfg_miso_data), .cfg_mosi_data(cfg_mosi_data),
      .cfg_match_en(cfg_match_en), .cfg_match_mask(cfg_match_mask),
      .cfg_match_value(cfg_match_value), .cfg_last(cfg_last),
      .busy(busy), .step_idx(step_idx), .seq_done(seq_done), .seq_abort(seq_abort)
   );

   always #5 sys_clk = ~sys_clk;

   // kind: 0 next chunk, 1 finish, 2 done, 3 abort
   always @(negedge sys_clk) begin
      if (rst && (b.cmd_next_chunk || b.cmd_finish || seq_done || seq_abort)) begin
         obs = '{kind: b.cmd_next_chunk ? 2'd0 : b.cmd_finish ? 2'd1 : seq_done ? 2'd2 : 2'd3,
                 size: b.next_chunk_size, ms: b.fake_miso_select, os: b.fake_mosi_select,
                 md: b.fake_miso_data, od: b.fake_mosi_data, step: step_idx};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got kind=%0d size=%0d step=%0d required no event",
                     obs.kind, obs.size, obs.step);
         end else begin
            ex = exp_q.pop_front();
            if ({obs.kind, obs.size, obs.ms, obs.os, obs.md, obs.od} !==
                {ex.kind, ex.size, ex.ms, ex.os, ex.md, ex.od} || (!ex.kind[1] && obs.step !== ex.step)) begin
               errors++;
               $display("FAIL event got kind=%0d size=%0d ms=%0d os=%0d md=%h od=%h step=%0d required kind=%0d size=%0d ms=%0d os=%0d md=%h od=%h step=%0d",
                        obs.kind, obs.size, obs.ms, obs.os, obs.md, obs.od, obs.step,
                        ex.kind, ex.size, ex.ms, ex.os, ex.md, ex.od, ex.step);
            end
         end
      end
      if (rst && (b.cmd_next_chunk || b.cmd_finish)) begin
         checks++;
         if ((b.cmd_next_chunk && b.cmd_finish) || (b.cmd_next_chunk && prev_next) || (b.cmd_finish && prev_fin)) begin
            errors++;
            $display("FAIL pulse_shape got next=%0d finish=%0d prev_next=%0d prev_fin=%0d required single-cycle exclusive pulses",
                     b.cmd_next_chunk, b.cmd_finish, prev_next, prev_fin);
         end
      end
      prev_next <= b.cmd_next_chunk;
      prev_fin <= b.cmd_finish;
   end

   task automatic push(input logic [1:0] k, input logic [3:0] s, input logic ms, input logic os,
                       input logic [8:0] md, input logic [8:0] od, input logic [1:0] st);
      exp_q.push_back('{k, s, ms, os, md, od, st});
   endtask

   task automatic push_b(input logic [3:0] s1);
      push(0, 3, 0, 0, 0, 0, 0);
      push(0, s1, 0, 0, 0, 0, 1);
      push(0, 8, 1, 0, 9'h048, 0, 2);
      push(0, 5, 0, 1, 0, 9'h1AB, 3);
      push(1, 0, 0, 1, 0, 9'h1AB, 3);
      push(2, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic write_desc(input logic [1:0] a, input logic [3:0] s, input logic ms, input logic os,
                             input logic [8:0] md, input logic [8:0] od, input logic men,
                             input logic [8:0] mk, input logic [8:0] v, input logic l);
      tick();
      cfg_we = 1; cfg_addr = a; cfg_size = s; cfg_miso_sel = ms; cfg_mosi_sel = os;
      cfg_miso_data = md; cfg_mosi_data = od; cfg_match_en = men; cfg_match_mask = mk;
      cfg_match_value = v; cfg_last = l;
      tick();
      cfg_we = 0;
   endtask

   task automatic wait_for(input int k, input string name);
      checks++;
      for (int i = 0; i < 40; i++) begin
         @(negedge sys_clk);
         if ((k == 0 && b.cmd_next_chunk) || (k == 1 && b.cmd_finish) || (k == 2 && seq_done) || (k == 3 && seq_abort))
            return;
      end
      errors++;
      $display("FAIL timeout_%s got no pulse required pulse within 40 cycles", name);
   endtask

   task automatic ready(input logic [8:0] m);
      tick();
      b.bus_ready = 1; b.real_mosi_data = m;
      tick();
      b.bus_ready = 0;
   endtask

   task automatic chunk(input logic [8:0] m);
      wait_for(0, "next");
      ready(m);
   endtask

   task automatic start();
      tick();
      b.comm_active = 1;
   endtask

   task automatic finish_run();
      wait_for(1, "finish");
      tick();
      b.comm_active = 0;
      wait_for(2, "done");
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_done got=%0d required=0", busy);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1; enable = 0; cfg_we = 0; cfg_addr = 0; cfg_size = 0;
      cfg_miso_sel = 0; cfg_mosi_sel = 0; cfg_match_en = 0; cfg_last = 0;
      cfg_miso_data = 0; cfg_mosi_data = 0; cfg_match_mask = 0; cfg_match_value = 0;
      b.comm_active = 0; b.bus_ready = 0; b.real_mosi_data = 0;
      #1 rst = 0;
      #5;
      checks++;
      if ({b.cmd_next_chunk, b.cmd_finish, b.next_chunk_size, b.fake_miso_select, b.fake_mosi_select,
           b.fake_miso_data, b.fake_mosi_data, busy, step_idx, seq_done, seq_abort} !== '0) begin
         errors++;
         $display("FAIL reset_state got size=%0d busy=%0d step=%0d required all zero", b.next_chunk_size, busy, step_idx);
      end
      @(posedge sys_clk);
      #3 rst = 1;
      enable = 1;
      // basic three-step run with a passing match on step 0
      write_desc(0, 3, 0, 0, 0, 0, 1, 9'h007, 9'h006, 0);
      write_desc(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
      write_desc(2, 8, 1, 0, 9'h048, 0, 0, 0, 0, 1);
      push(0, 3, 0, 0, 0, 0, 0);
      push(0, 9, 0, 0, 0, 0, 1);
      push(0, 8, 1, 0, 9'h048, 0, 2);
      push(1, 0, 1, 0, 9'h048, 0, 2);
      push(2, 0, 0, 0, 0, 0, 0);
      start();
      chunk(9'b110); chunk(9'h0AA); chunk(9'h155);
      finish_run();
      // mismatch on step 0 ends the sequence at once
      push(0, 3, 0, 0, 0, 0, 0);
      push(1, 0, 0, 0, 0, 0, 0);
      push(2, 0, 0, 0, 0, 0, 0);
      start();
      chunk(9'b101);
      finish_run();
      // table B: no last flag, no match -> all four steps
      write_desc(0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      write_desc(2, 8, 1, 0, 9'h048, 0, 0, 0, 0, 0);
      write_desc(3, 5, 0, 1, 0, 9'h1AB, 0, 0, 0, 0);
      push_b(9);
      start();
      chunk(0); chunk(0); chunk(0); chunk(0);
      finish_run();
      // abort on step 1 with a same-cycle bus_ready
      push(0, 3, 0, 0, 0, 0, 0);
      push(0, 9, 0, 0, 0, 0, 1);
      push(3, 0, 0, 0, 0, 0, 0);
      start();
      chunk(0);
      wait_for(0, "next");
      tick();
      b.bus_ready = 1; b.comm_active = 0;
      tick();
      b.bus_ready = 0;
      wait_for(3, "abort");
      checks++;
      if ({busy, b.next_chunk_size, b.fake_miso_select, b.fake_mosi_select, b.fake_miso_data, b.fake_mosi_data} !== '0) begin
         errors++;
         $display("FAIL abort_clear got busy=%0d size=%0d required all zero", busy, b.next_chunk_size);
      end
      // enable low in IDLE: nothing issued
      enable = 0;
      tick();
      b.comm_active = 1;
      repeat (6) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL enable_low_busy got=%0d required=0", busy);
      end
      b.comm_active = 0;
      enable = 1;
      tick();
      // write while busy is ignored, now and on the rerun
      push_b(9);
      start();
      wait_for(0, "next");
      write_desc(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      ready(0);
      chunk(0); chunk(0); chunk(0);
      finish_run();
      push_b(9);
      start();
      chunk(0); chunk(0); chunk(0); chunk(0);
      finish_run();
      // IDLE write takes effect; a write in the start cycle is dropped
      write_desc(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      push_b(5);
      tick();
      b.comm_active = 1;
      cfg_we = 1; cfg_addr = 0; cfg_size = 7;
      tick();
      cfg_we = 0;
      chunk(0); chunk(0); chunk(0); chunk(0);
      finish_run();
      // asynchronous reset mid-WAIT clears outputs and table
      push(0, 3, 0, 0, 0, 0, 0);
      start();
      wait_for(0, "next");
      tick();
      #2 rst = 0;
      #1;
      checks++;
      if ({b.cmd_next_chunk, b.cmd_finish, b.next_chunk_size, b.fake_miso_select, b.fake_mosi_select,
           b.fake_miso_data, b.fake_mosi_data, busy, step_idx, seq_done, seq_abort} !== '0) begin
         errors++;
         $display("FAIL async_reset got size=%0d busy=%0d step=%0d required all zero", b.next_chunk_size, busy, step_idx);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_before_reset got=%0d required=0", exp_q.size());
      end
      for (int s = 0; s < 4; s++) push(0, 1, 0, 0, 0, 0, 2'(s));
      push(1, 0, 0, 0, 0, 0, 3);
      push(2, 0, 0, 0, 0, 0, 0);
      #2 rst = 1;
      chunk(0); chunk(0); chunk(0); chunk(0);
      finish_run();
      repeat (3) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_events got=%0d required=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/chunk_sequencer.md
Name: chunk_sequencer

Overview:
- Programmable replacement for hard-coded MITM state machines.
- Holds a small table of chunk descriptors and steps the bus control module through them, one chunk per step.
- Each step gives: chunk size, fake MISO/MOSI selects and data, an optional MOSI match condition, and a last flag.
- Sits between the bus control module and a host/config source, so new attacks need a table reload, not new RTL.

Parameters:
BUF_SIZE, 9, width of bus control data buffers
CHUNK_SIZE_WIDTH, $clog2(BUF_SIZE+1), width of chunk size fields
NUM_STEPS, 4, descriptor table depth (power of two, >=2)
STEP_IDX_WIDTH, $clog2(NUM_STEPS), table index width

Ports:
sys_clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
enable  input  1  1 = sequencing allowed; sampled only in IDLE
comm_active  input  1  from bus control: transaction in progress
bus_ready  input  1  from bus control: current chunk complete
real_mosi_data  input  BUF_SIZE  captured MOSI chunk from bus control
cfg_we  input  1  descriptor write strobe
cfg_addr  input  STEP_IDX_WIDTH  descriptor index
cfg_size  input  CHUNK_SIZE_WIDTH  chunk size in bits, 1..BUF_SIZE
cfg_miso_sel, cfg_mosi_sel  input  1 each  fake-line selects for the step
cfg_miso_data, cfg_mosi_data  input  BUF_SIZE each  fake data, MSB-first aligned
cfg_match_en  input  1  enable match check at end of step
cfg_match_mask, cfg_match_value  input  BUF_SIZE each  check: (real_mosi_data & mask) == value
cfg_last  input  1  step is final
cmd_next_chunk  output  1  one-cycle pulse to bus control
cmd_finish  output  1  one-cycle pulse to bus control
next_chunk_size  output  CHUNK_SIZE_WIDTH  size for bus control
fake_miso_select, fake_mosi_select  output  1 each  fake-line selects
fake_miso_data, fake_mosi_data  output  BUF_SIZE each  fake data
busy  output  1  high whenever not in IDLE
step_idx  output  STEP_IDX_WIDTH  current step
seq_done  output  1  one-cycle pulse: transaction ended normally
seq_abort  output  1  one-cycle pulse: comm_active fell before the finish was issued

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, table cleared to 0, state IDLE.
- Table writes:
  - Accepted on a sys_clk edge with cfg_we=1 and busy=0.
  - Ignored while busy=1.
  - A write in the same cycle as a start is ignored.
- States: IDLE, ISSUE, WAIT, FIN_ISSUE, FIN_WAIT.
- IDLE: if comm_active=1 and enable=1:
  - step_idx<=0.
  - Load step 0 size, selects and data onto the outputs.
  - cmd_next_chunk<=1; go to ISSUE.
- ISSUE: cmd_next_chunk<=0; go to WAIT. The pulse is exactly 1 cycle.
- WAIT on bus_ready=1, evaluating step s:
  - mismatch = match_en[s] and ((real_mosi_data & mask[s]) != value[s]).
  - End the sequence if mismatch, or last[s], or s==NUM_STEPS-1.
  - On end: next_chunk_size<=0, cmd_finish<=1, go to FIN_ISSUE.
    - If mismatch, both fake selects <=0, so the rest of the transaction is forwarded.
    - Otherwise the selects hold step s values.
  - Else: step_idx<=s+1, load step s+1 onto the outputs, cmd_next_chunk<=1, go to ISSUE.
- Latency: bus_ready to the next command pulse is 1 cycle.
- FIN_ISSUE: cmd_finish<=0; go to FIN_WAIT.
- FIN_WAIT: on comm_active=0, go to IDLE:
  - selects <=0, next_chunk_size<=0, data cleared.
  - seq_done pulses for 1 cycle.
- comm_active=0 while in ISSUE or WAIT:
  - Go to IDLE with the same clears; seq_abort pulses; no cmd_finish is issued.
  - This check has priority over bus_ready in the same cycle.
- cmd_next_chunk and cmd_finish are never high together.
- step_idx never wraps.
- A descriptor with size 0 is treated as size 1.
- enable=0 while in IDLE: no commands are issued; bus control runs with its default forward settings.
- Changing enable while busy has no effect until the next IDLE.

Test Plan:
- Table {0: size 3, match mask 0x007 value 0x006; 1: size 9; 2: size 8, miso_sel=1, miso_data 0x048 (0x24<<1), last}, MOSI 110 then addr -> three 1-cycle cmd_next_chunk pulses with sizes 3, 9, 8; fake_miso_select=1 on step 2; cmd_finish after step 2's bus_ready; seq_done when comm_active falls.
- Same table, first chunk 101 -> mismatch: cmd_finish follows step 0's bus_ready, selects 0, step_idx=0, no further cmd_next_chunk.
- No last flag anywhere, all match checks off -> 4 chunks issued, then cmd_finish; step_idx peaks at 3, no wrap.
- comm_active drops in WAIT on step 1, in the same cycle as bus_ready=1 -> seq_abort pulse, no cmd_finish, outputs cleared, busy=0 the next cycle.
- cfg_we during busy changes step 1 size to 5 -> ignored; the rerun after returning to IDLE shows the original size. A write in IDLE takes effect on the next transaction.
- rst asserted mid-WAIT, asynchronously between clock edges -> all outputs 0 immediately, table reads 0. After release with enable=1 and comm_active=1 -> starts at step 0 with size 1 (zero-size rule).
